// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants: arbiter state encoding, default transfer timeout,
// transmitter oversampling, and the two-requester round-robin pick.
package uart_tx_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT
  } arb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 200000;

  // Transmitter oversampling: samples per bit and its counter width.
  localparam int TX_OVERSAMPLE = 16;
  localparam int TX_OVS_W      = 4;

  // With both requesters valid the pointer wins; otherwise the only valid one.
  function automatic logic arb_pick(input logic ptr, input logic v0, input logic v1);
    if (v0 && v1) begin
      return ptr;
    end
    return v1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from two requesters into one UART
// transmitter, with a watchdog on the transmitter's completion pulse.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TO_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ack,
  output logic       tx_start,
  output logic [7:0] dout,
  input  logic       tx_done,
  output logic       busy,
  output logic       grant,
  output logic       err_timeout,
  input  logic       err_clear
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            grant_q, grant_d;
  logic [7:0]      dout_q, dout_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            sel;
  logic            finish;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tx_start = 1'b0;
    req0_ack = 1'b0;
    req1_ack = 1'b0;
    finish   = 1'b0;
    sel      = arb_pick(ptr_q, req0_valid, req1_valid);

    if (err_clear) begin
      err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = sel;
          dout_d  = sel ? req1_data : req0_data;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the terminal count is a normal finish, not a timeout.
        if (tx_done) begin
          finish = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
        if (finish) begin
          req0_ack = ~grant_q;
          req1_ack = grant_q;
          ptr_d    = ~grant_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      dout_q  <= 8'h00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign grant       = grant_q;
  assign dout        = dout_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table plus hand-written
// sequences for timeout, coincident completion, reset mid-transfer and round-robin.
module tb_uart_tx_arbiter;

  localparam int TO_CYC = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ack;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ack;
  logic       tx_start;
  logic [7:0] dout;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       grant;
  logic       err_timeout;
  logic       err_clear = 1'b0;

  int total = 0;
  int bad = 0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ack(req1_ack),
    .tx_start(tx_start), .dout(dout), .tx_done(tx_done),
    .busy(busy), .grant(grant), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       txd;
    logic       clr;
    logic       e_busy;
    logic       e_grant;
    logic [7:0] e_dout;
    logic       e_txs;
    logic       e_a0;
    logic       e_a1;
    logic       e_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic v1,
                              input logic [7:0] d1, input logic txd, input logic clr,
                              input logic eb, input logic eg, input logic [7:0] ed,
                              input logic et, input logic ea0, input logic ea1,
                              input logic ee);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.txd = txd; v.clr = clr;
    v.e_busy = eb; v.e_grant = eg; v.e_dout = ed; v.e_txs = et;
    v.e_a0 = ea0; v.e_a1 = ea1; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge, reset released.
  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    tx_done = 1'b0; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_start(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, found, 1'b1);
  endtask

  initial begin
    int acks;
    int ack_k;
    int extra;
    int nstart;
    int nack;
    int since;
    int ackw;
    logic [7:0] got[4];
    logic [7:0] want[4];

    vecs[0]  = mk(1, 8'hA5, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 8'hA5, 0, 8'h00, 0, 0,  1, 0, 8'hA5, 1, 0, 0, 0);
    vecs[2]  = mk(1, 8'hA5, 0, 8'h00, 0, 0,  1, 0, 8'hA5, 0, 0, 0, 0);
    vecs[3]  = mk(1, 8'hA5, 0, 8'h00, 1, 0,  1, 0, 8'hA5, 0, 1, 0, 0);
    vecs[4]  = mk(0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 8'hA5, 0, 0, 0, 0);
    vecs[5]  = mk(1, 8'h11, 1, 8'h22, 0, 0,  0, 0, 8'hA5, 0, 0, 0, 0);
    vecs[6]  = mk(1, 8'h11, 1, 8'h22, 1, 0,  1, 1, 8'h22, 1, 0, 0, 0);
    vecs[7]  = mk(1, 8'h11, 1, 8'h22, 0, 0,  1, 1, 8'h22, 0, 0, 0, 0);
    vecs[8]  = mk(1, 8'h11, 1, 8'h22, 1, 0,  1, 1, 8'h22, 0, 0, 1, 0);
    vecs[9]  = mk(1, 8'h11, 1, 8'h22, 0, 0,  0, 1, 8'h22, 0, 0, 0, 0);
    vecs[10] = mk(1, 8'h11, 1, 8'h22, 0, 0,  1, 0, 8'h11, 1, 0, 0, 0);
    vecs[11] = mk(1, 8'h11, 1, 8'h22, 1, 0,  1, 0, 8'h11, 0, 1, 0, 0);
    vecs[12] = mk(1, 8'h11, 1, 8'h22, 0, 0,  0, 0, 8'h11, 0, 0, 0, 0);
    vecs[13] = mk(1, 8'h11, 1, 8'h22, 0, 0,  1, 1, 8'h22, 1, 0, 0, 0);
    vecs[14] = mk(1, 8'h11, 1, 8'h22, 1, 0,  1, 1, 8'h22, 0, 0, 1, 0);
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 0, 1,  0, 1, 8'h22, 0, 0, 0, 0);

    // Cycle table from reset: outputs sampled mid-cycle with that cycle's inputs.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1;
      tx_done = vecs[i].txd; err_clear = vecs[i].clr;
      @(negedge clk);
      $display("vec %0d: busy=%0b grant=%0b dout=%02h tx_start=%0b ack0=%0b ack1=%0b err=%0b",
               i, busy, grant, dout, tx_start, req0_ack, req1_ack, err_timeout);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_grant", i), grant, vecs[i].e_grant);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].e_dout);
      chk($sformatf("vec%0d_tx_start", i), tx_start, vecs[i].e_txs);
      chk($sformatf("vec%0d_ack0", i), req0_ack, vecs[i].e_a0);
      chk($sformatf("vec%0d_ack1", i), req1_ack, vecs[i].e_a1);
      chk($sformatf("vec%0d_err", i), err_timeout, vecs[i].e_err);
      @(posedge clk); #1;
    end

    // Timeout: WAIT lasts TO_CYC cycles; err_clear held through the terminal
    // cycle so the set must win.
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h5A; err_clear = 1'b1;
    wait_start("to_tx_start");
    acks = 0; ack_k = -1; extra = 0;
    for (int k = 1; k <= TO_CYC + 1; k++) begin
      @(posedge clk); #1;
      if (k == TO_CYC + 1) begin
        err_clear = 1'b0;
        req0_valid = 1'b0;
      end
      @(negedge clk);
      if (req0_ack || req1_ack) begin
        acks++;
        ack_k = k;
      end
      if (tx_start) extra++;
      if (k == TO_CYC) chk("to_err_before_set", err_timeout, 1'b0);
    end
    $display("timeout: acks=%0d ack_cycle=%0d err=%0b busy=%0b", acks, ack_k, err_timeout, busy);
    chk("to_err_set_wins", err_timeout, 1'b1);
    chk("to_idle", busy, 1'b0);
    chk("to_ack_count", acks, 1);
    chk("to_ack_cycle", ack_k, TO_CYC);
    chk("to_no_second_start", extra, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err_sticky", err_timeout, 1'b1);
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", err_timeout, 1'b0);

    // tx_done on the terminal count is a normal completion.
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hC3;
    wait_start("co_tx_start");
    acks = 0; ack_k = -1;
    for (int k = 1; k <= TO_CYC + 1; k++) begin
      @(posedge clk); #1;
      tx_done = (k == TO_CYC);
      if (k == TO_CYC + 1) req0_valid = 1'b0;
      @(negedge clk);
      if (req0_ack) begin
        acks++;
        ack_k = k;
      end
    end
    tx_done = 1'b0;
    $display("coincident: acks=%0d ack_cycle=%0d err=%0b", acks, ack_k, err_timeout);
    chk("co_ack_count", acks, 1);
    chk("co_ack_cycle", ack_k, TO_CYC);
    chk("co_no_err", err_timeout, 1'b0);
    chk("co_idle", busy, 1'b0);

    // Reset asserted three cycles into WAIT abandons the byte.
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h77;
    wait_start("rst_tx_start");
    repeat (3) begin
      @(posedge clk); #1;
    end
    req0_valid = 1'b1; req0_data = 8'h33;
    #1 reset = 1'b1;
    #1;
    $display("reset mid-wait: busy=%0b grant=%0b dout=%02h err=%0b", busy, grant, dout, err_timeout);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_acks", {req0_ack, req1_ack}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_acks_held", {req0_ack, req1_ack}, 2'b00);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_release_no_start", tx_start, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    $display("after reset: tx_start=%0b grant=%0b dout=%02h", tx_start, grant, dout);
    chk("rst_next_start", tx_start, 1'b1);
    chk("rst_next_grant", grant, 1'b0);
    chk("rst_next_dout", dout, 8'h33);

    // Both requesters valid continuously; transmitter answers 3 cycles after start.
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h11; want[3] = 8'h22;
    for (int j = 0; j < 4; j++) got[j] = 8'h00;
    nstart = 0; nack = 0; since = -1;
    for (int i = 0; i < 80 && nack < 4; i++) begin
      if (i != 0) begin
        @(posedge clk); #1;
      end
      tx_done = (since == 2);
      @(negedge clk);
      if (req0_ack || req1_ack) begin
        ackw = nack % 2;
        chk($sformatf("rr_ack%0d_who", nack), {req0_ack, req1_ack}, ackw == 0 ? 2'b10 : 2'b01);
        nack++;
        since = -1;
      end else if (tx_start) begin
        if (nstart < 4) got[nstart] = dout;
        nstart++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
    end
    @(posedge clk); #1 tx_done = 1'b0;
    $display("round-robin: starts=%0d acks=%0d bytes=%02h %02h %02h %02h",
             nstart, nack, got[0], got[1], got[2], got[3]);
    chk("rr_starts", nstart, 4);
    chk("rr_acks", nack, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("rr_byte%0d", j), got[j], want[j]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
